// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between the CPU and debug/loader ports.
// One access at a time: IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (ready pulse) -> IDLE.
module sram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    // owner/last_grant encoding: 0 = cpu, 1 = dbg
    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              grant_dbg;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        grant_dbg    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // On a tie the port that was not granted last time wins.
                    grant_dbg    = dbg_req && (!cpu_req || !last_grant_q);
                    owner_d      = grant_dbg;
                    last_grant_d = grant_dbg;
                    we_d         = grant_dbg ? dbg_we    : cpu_we;
                    addr_d       = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d      = grant_dbg ? dbg_wdata : cpu_wdata;
                    cnt_d        = CNT_INIT;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) dbg_rdata_d = sram_dq_in;
                        else         cpu_rdata_d = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 4'd0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Outputs decode purely from registered state.
    logic in_access, do_write, do_read;
    assign in_access   = (state_q == ACCESS);
    assign do_write    = in_access && we_q;
    assign do_read     = in_access && !we_q;

    assign busy        = (state_q != IDLE);
    assign sram_addr   = in_access ? addr_q : '0;
    assign sram_dq_out = do_write ? wdata_q : '0;
    assign sram_dq_oe  = do_write;
    assign sram_ce_n   = !in_access;
    assign sram_oe_n   = !do_read;
    assign sram_we_n   = !do_write;
    assign cpu_ready   = (state_q == DONE) && !owner_q;
    assign dbg_ready   = (state_q == DONE) && owner_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model with its own memory image.
module tb_sram_arbiter;

    localparam int WC = 2;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        cpu_ready, dbg_ready, busy;
    logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    // Second instance with a single wait cycle
    logic        w1_cpu_req, w1_cpu_we, w1_dbg_req, w1_dbg_we;
    logic [15:0] w1_cpu_addr, w1_cpu_wdata, w1_dbg_addr, w1_dbg_wdata;
    logic [15:0] w1_cpu_rdata, w1_dbg_rdata;
    logic        w1_cpu_ready, w1_dbg_ready, w1_busy;
    logic [15:0] w1_sram_addr, w1_sram_dq_out, w1_sram_dq_in;
    logic        w1_sram_dq_oe, w1_sram_ce_n, w1_sram_oe_n, w1_sram_we_n;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WC)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .busy(busy), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(w1_cpu_req), .cpu_we(w1_cpu_we), .cpu_addr(w1_cpu_addr), .cpu_wdata(w1_cpu_wdata),
        .cpu_rdata(w1_cpu_rdata), .cpu_ready(w1_cpu_ready),
        .dbg_req(w1_dbg_req), .dbg_we(w1_dbg_we), .dbg_addr(w1_dbg_addr), .dbg_wdata(w1_dbg_wdata),
        .dbg_rdata(w1_dbg_rdata), .dbg_ready(w1_dbg_ready),
        .busy(w1_busy), .sram_addr(w1_sram_addr), .sram_dq_out(w1_sram_dq_out),
        .sram_dq_oe(w1_sram_dq_oe), .sram_dq_in(w1_sram_dq_in), .sram_ce_n(w1_sram_ce_n),
        .sram_oe_n(w1_sram_oe_n), .sram_we_n(w1_sram_we_n)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 257) ^ 16'h3C5A;
    endfunction

    // SRAM model for the main instance (256 words, low address byte)
    logic [15:0] sram_mem [0:255];
    bit          sram_init = 1'b0;
    assign sram_dq_in = sram_mem[sram_addr[7:0]];
    always @(posedge Clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    assign w1_sram_dq_in = w1_sram_addr ^ 16'hA5A5;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    // Reference model: m_k counts cycles since the grant (0 = idle,
    // 1..WC = strobes active, WC+1 = completion cycle).
    logic [15:0] ref_mem [0:255];
    bit          ref_init = 1'b0;
    int          m_k = 0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = 16'h0, m_wdata = 16'h0;
    logic [15:0] m_cpu_rd = 16'h0, m_dbg_rd = 16'h0;

    initial begin
        forever begin
            @(posedge Clk);
            if (!ref_init) begin
                for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
                ref_init = 1'b1;
            end
            if (!Reset) begin
                m_k = 0; m_last = 1'b1; m_cpu_rd = 16'h0; m_dbg_rd = 16'h0;
            end else if (m_k == 0) begin
                if (cpu_req || dbg_req) begin
                    m_owner = (cpu_req && dbg_req) ? !m_last : dbg_req;
                    m_last  = m_owner;
                    m_we    = m_owner ? dbg_we : cpu_we;
                    m_addr  = m_owner ? dbg_addr : cpu_addr;
                    m_wdata = m_owner ? dbg_wdata : cpu_wdata;
                    if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
                    m_k = 1;
                end
            end else if (m_k <= WC) begin
                if (m_k == WC && !m_we) begin
                    if (m_owner) m_dbg_rd = ref_mem[m_addr[7:0]];
                    else         m_cpu_rd = ref_mem[m_addr[7:0]];
                end
                m_k++;
            end else begin
                m_k = 0;
            end
        end
    end

    initial begin
        bit acc, done;
        forever begin
            @(negedge Clk);
            acc  = (m_k >= 1) && (m_k <= WC);
            done = (m_k == WC + 1);
            chk1("m_busy", busy, m_k != 0);
            chk1("m_ce_n", sram_ce_n, !acc);
            chk1("m_oe_n", sram_oe_n, !(acc && !m_we));
            chk1("m_we_n", sram_we_n, !(acc && m_we));
            chk1("m_dq_oe", sram_dq_oe, acc && m_we);
            chk16("m_addr", sram_addr, acc ? m_addr : 16'h0);
            chk16("m_dq_out", sram_dq_out, (acc && m_we) ? m_wdata : 16'h0);
            chk1("m_cpu_ready", cpu_ready, done && !m_owner);
            chk1("m_dbg_ready", dbg_ready, done && m_owner);
            chk16("m_cpu_rdata", cpu_rdata, m_cpu_rd);
            chk16("m_dbg_rdata", dbg_rdata, m_dbg_rd);
        end
    end

    task automatic reset_outputs_check(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_cpu_ready"}, cpu_ready, 1'b0);
        chk1({tag, "_dbg_ready"}, dbg_ready, 1'b0);
        chk1({tag, "_ce_n"}, sram_ce_n, 1'b1);
        chk1({tag, "_oe_n"}, sram_oe_n, 1'b1);
        chk1({tag, "_we_n"}, sram_we_n, 1'b1);
        chk1({tag, "_dq_oe"}, sram_dq_oe, 1'b0);
        chk16({tag, "_addr"}, sram_addr, 16'h0);
        chk16({tag, "_dq_out"}, sram_dq_out, 16'h0);
        chk16({tag, "_cpu_rdata"}, cpu_rdata, 16'h0);
        chk16({tag, "_dbg_rdata"}, dbg_rdata, 16'h0);
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        Reset = 1'b0;
        set_cpu(1'b1, 1'b0, 16'h0, 16'h0);
        set_dbg(1'b1, 1'b0, 16'h0, 16'h0);
        w1_cpu_req = 1'b0; w1_cpu_we = 1'b0; w1_cpu_addr = 16'h0; w1_cpu_wdata = 16'h0;
        w1_dbg_req = 1'b0; w1_dbg_we = 1'b0; w1_dbg_addr = 16'h0; w1_dbg_wdata = 16'h0;

        // Reset held two cycles with both requests high
        cyc(); reset_outputs_check("rst0");
        cyc(); reset_outputs_check("rst1");
        Reset = 1'b1;
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        cyc(); chk1("post_rst_idle", busy, 1'b0);

        // CPU write 0x0040 <- 0x1234
        set_cpu(1'b1, 1'b1, 16'h0040, 16'h1234);
        for (int c = 1; c <= 2; c++) begin
            cyc();
            chk1("wr_ce_n", sram_ce_n, 1'b0);
            chk1("wr_we_n", sram_we_n, 1'b0);
            chk1("wr_dq_oe", sram_dq_oe, 1'b1);
            chk16("wr_addr", sram_addr, 16'h0040);
            chk16("wr_dq_out", sram_dq_out, 16'h1234);
            chk1("wr_dbg_ready", dbg_ready, 1'b0);
        end
        cyc();
        chk1("wr_cpu_ready", cpu_ready, 1'b1);
        chk1("wr_dbg_ready3", dbg_ready, 1'b0);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        cyc(); chk1("wr_ready_pulse", cpu_ready, 1'b0);

        // CPU read back 0x0040
        set_cpu(1'b1, 1'b0, 16'h0040, 16'h0);
        for (int c = 1; c <= 2; c++) begin
            cyc();
            chk1("rd_oe_n", sram_oe_n, 1'b0);
            chk1("rd_we_n", sram_we_n, 1'b1);
            chk1("rd_dq_oe", sram_dq_oe, 1'b0);
        end
        cyc();
        chk1("rd_cpu_ready", cpu_ready, 1'b1);
        chk16("rd_cpu_rdata", cpu_rdata, 16'h1234);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (10) cyc();
        chk16("rd_hold", cpu_rdata, 16'h1234);

        // dbg write 0x0041 <- 0xBEEF (also leaves last grant on dbg)
        set_dbg(1'b1, 1'b1, 16'h0041, 16'hBEEF);
        repeat (3) cyc();
        chk1("dwr_dbg_ready", dbg_ready, 1'b1);
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();

        // Contention: CPU first, dbg served in the following IDLE
        set_cpu(1'b1, 1'b0, 16'h0040, 16'h0);
        set_dbg(1'b1, 1'b0, 16'h0041, 16'h0);
        repeat (3) cyc();
        chk1("tie1_cpu_ready", cpu_ready, 1'b1);
        chk1("tie1_dbg_ready3", dbg_ready, 1'b0);
        chk16("tie1_cpu_rdata", cpu_rdata, 16'h1234);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        cyc(); chk1("tie1_idle4", busy, 1'b0);
        cyc(); chk16("tie1_dbg_addr5", sram_addr, 16'h0041);
        cyc();
        cyc();
        chk1("tie1_dbg_ready7", dbg_ready, 1'b1);
        chk16("tie1_dbg_rdata", dbg_rdata, 16'hBEEF);
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();

        // Second contention: CPU wins again
        set_cpu(1'b1, 1'b0, 16'h0041, 16'h0);
        set_dbg(1'b1, 1'b0, 16'h0040, 16'h0);
        repeat (3) cyc();
        chk1("tie2_cpu_ready", cpu_ready, 1'b1);
        chk16("tie2_cpu_rdata", cpu_rdata, 16'hBEEF);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) cyc();
        chk1("tie2_dbg_ready", dbg_ready, 1'b1);
        chk16("tie2_dbg_rdata", dbg_rdata, 16'h1234);
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();

        // Reset during cycle 1 of a dbg write
        set_dbg(1'b1, 1'b1, 16'h0050, 16'h7777);
        cyc();
        chk1("rstmid_we_n1", sram_we_n, 1'b0);
        Reset = 1'b0;
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();
        reset_outputs_check("rstmid");
        Reset = 1'b1;
        cyc();
        set_cpu(1'b1, 1'b0, 16'h0050, 16'h0);
        set_dbg(1'b1, 1'b0, 16'h0041, 16'h0);
        repeat (3) cyc();
        chk1("tie3_cpu_ready", cpu_ready, 1'b1);
        chk1("tie3_dbg_ready", dbg_ready, 1'b0);
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) cyc();
        chk1("tie3_dbg_ready7", dbg_ready, 1'b1);
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();

        // Single-wait-cycle instance: CPU read of 0x0040
        w1_cpu_req = 1'b1; w1_cpu_we = 1'b0; w1_cpu_addr = 16'h0040;
        cyc();
        chk1("w1_ce_n1", w1_sram_ce_n, 1'b0);
        chk1("w1_oe_n1", w1_sram_oe_n, 1'b0);
        chk1("w1_we_n1", w1_sram_we_n, 1'b1);
        chk1("w1_dq_oe1", w1_sram_dq_oe, 1'b0);
        chk16("w1_dq_out1", w1_sram_dq_out, 16'h0);
        chk16("w1_addr1", w1_sram_addr, 16'h0040);
        chk1("w1_busy1", w1_busy, 1'b1);
        chk1("w1_ready1", w1_cpu_ready, 1'b0);
        cyc();
        chk1("w1_ready2", w1_cpu_ready, 1'b1);
        chk1("w1_dbg_ready2", w1_dbg_ready, 1'b0);
        chk1("w1_ce_n2", w1_sram_ce_n, 1'b1);
        chk16("w1_rdata2", w1_cpu_rdata, 16'hA5E5);
        chk16("w1_dbg_rdata2", w1_dbg_rdata, 16'h0);
        w1_cpu_req = 1'b0;
        cyc();
        chk1("w1_ready3", w1_cpu_ready, 1'b0);
        chk1("w1_busy3", w1_busy, 1'b0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 99) != 0);
            if (cpu_req && cpu_ready) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 2) == 0)
                set_cpu(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
            if (dbg_req && dbg_ready) dbg_req = 1'b0;
            else if (!dbg_req && $urandom_range(0, 2) == 0)
                set_dbg(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
            cyc();
        end
        Reset = 1'b1;
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_dbg(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (6) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single board SRAM between two requesters: the slc3 CPU memory path (port `cpu`) and the debug/program loader path (port `dbg`, driven from Switches/Continue). The block arbitrates round-robin, sequences one SRAM access at a time with a fixed number of wait cycles, and returns read data and a one-cycle completion pulse to the granted requester. It sits between the slc3 datapath MAR/MDR logic and the SRAM pins.

## Interface

- `ADDR_W`, 16, address width of both ports and SRAM.
- `DATA_W`, 16, data width.
- `WAIT_CYCLES`, 2, cycles the SRAM strobes stay active per access; legal range 1..15.

- `Clk`  in  1  system clock, rising-edge.
- `Reset`  in  1  one clock; reset is synchronous and active-low.
- `cpu_req`  in  1  CPU access request; hold high until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` high.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  last CPU read result.
- `cpu_ready`  out  1  one-cycle completion pulse for CPU.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ready`: same as the CPU set, for the debug/loader port.
- `busy`  out  1  high in every non-IDLE state.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_dq_out`  out  DATA_W  write data to SRAM.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_out`.
- `sram_dq_in`  in  DATA_W  read data from SRAM.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1  active-low SRAM strobes.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any request is high, grant one port. At the same edge, latch owner, addr, we, and wdata, load `cnt` with WAIT_CYCLES-1, and go to ACCESS. If no request is high, stay in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesters: the port that is not `last_grant` wins.
  - `last_grant` updates on every grant and resets to `dbg`, so the CPU wins the first tie. Sustained contention alternates strictly.
- ACCESS:
  - Drive `sram_addr` from the latched address and set `sram_ce_n`=0.
  - Read: `sram_oe_n`=0, `sram_we_n`=1, `sram_dq_oe`=0.
  - Write: `sram_oe_n`=1, `sram_we_n`=0, `sram_dq_oe`=1, `sram_dq_out` driven from the latched wdata.
  - Decrement `cnt` each cycle. When `cnt`==0, go to DONE at the edge. For a read, the same edge captures `sram_dq_in` into the owner's rdata register.
- DONE: all strobes inactive and `sram_dq_oe`=0. The owner's ready is 1 for exactly this cycle. Next state is always IDLE.
- rdata registers hold their value until that port's next read completes. A write never changes rdata.
- Every output decodes from registers only; there is no combinational path from inputs to outputs.
- Non-owner requests are ignored while `busy`=1 and are served in a later IDLE.

## Timing

- Reset values, applied at the first edge with Reset=0:
  - state=IDLE, `last_grant`=dbg, `busy`=0.
  - `cpu_ready`=`dbg_ready`=0, `cpu_rdata`=`dbg_rdata`=0.
  - `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0.
  - `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1.
- Latency: request sampled in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES, and ready high in cycle WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles. DONE always passes through IDLE.
- Handshake:
  - req, we, addr, and wdata must stay stable from assertion until ready.
  - The requester must drive req low in the cycle after ready; a req still high in IDLE starts a new access.
- Reset mid-access: at the next edge the FSM returns to IDLE and strobes go inactive. No ready pulse is issued, and rdata is cleared. An in-progress write may be truncated.
- Requests asserted while Reset=0 are ignored.
- Simultaneous new request and DONE: the request waits for IDLE and is arbitrated there.

## Test plan

- Reset: hold Reset=0 for 2 cycles with both req high. All outputs stay at reset values and no ready pulse appears.
- CPU write, WAIT_CYCLES=2: cpu_req with we=1, addr=0x0040, wdata=0x1234 at cycle 0.
  - Cycles 1–2: `sram_ce_n`=0, `sram_we_n`=0, `sram_dq_oe`=1, `sram_addr`=0x0040, `sram_dq_out`=0x1234.
  - Cycle 3: `cpu_ready`=1.
  - `dbg_ready` stays 0 throughout.
- CPU read of 0x0040 from the SRAM model: `sram_oe_n`=0 in cycles 1–2. `cpu_rdata`=0x1234 in cycle 3 and is still 0x1234 ten cycles later.
- Contention: both req high at cycle 0, with dbg reading 0x0041.
  - `cpu_ready` in cycle 3; dbg is granted in the cycle-4 IDLE; `dbg_ready` in cycle 7.
  - Repeat the contention: the CPU wins again (alternation).
- Reset at cycle 1 of a dbg write: strobes go inactive at the next edge, `busy`=0, no `dbg_ready`, and the next tie grants the CPU.
- WAIT_CYCLES=1: a CPU read sampled at cycle 0 has ACCESS only in cycle 1 and `cpu_ready` in cycle 2.
